cmdhdr_cache: RTL and testbench

- Parametrised per-slot command-header cache for the AHCI port engine.
- Caches C_WORDS 64-bit words per command slot: header, CTBA, strip descriptor, PRD progress.
- Filled by the CTBA fetch engine. Read out (decoded) and partially written back by the port FSM.
- Adds over the previous generation: configurable slot count, a per-slot valid bitmap with invalidate, a miss flag, fill-priority stalling with correct capture tracking, and a configurable PRDBC step.

---
 rtl/cmdhdr_cache_if.sv | 10 +
 rtl/cmdhdr_cache.sv | 125 ++++++++++++
 tb/tb_cmdhdr_cache.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cmdhdr_cache_if.sv
// cmdhdr_cache_if: port-engine access handshake into the command-header cache
interface cmdhdr_cache_if #(parameter int SW = 5) ();
  logic          port_req;
  logic          port_we;
  logic [SW-1:0] port_slot;
  logic          port_ack;
  logic          port_miss;
  modport master (output port_req, port_we, port_slot, input port_ack, port_miss);
  modport slave (input port_req, port_we, port_slot, output port_ack, port_miss);
endinterface

// File: rtl/cmdhdr_cache.sv
// cmdhdr_cache: per-slot command-header cache with fill-priority RAM port, valid map and decoded readout
module cmdhdr_cache #(
  parameter int C_NUM_SLOTS = 32,
  parameter int C_WORDS = 4,
  parameter int C_PRDBC_STEP = 4,
  localparam int SW = $clog2(C_NUM_SLOTS),
  localparam int IW = $clog2(C_WORDS)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   fill_req,
  input  logic [SW-1:0]          fill_slot,
  input  logic [IW-1:0]          fill_idx,
  input  logic                   fill_we,
  input  logic [63:0]            fill_data,
  cmdhdr_cache_if.slave          acc,
  input  logic                   inv_req,
  input  logic [SW-1:0]          inv_slot,
  output logic [C_NUM_SLOTS-1:0] valid_map,
  input  logic                   prdbc_incr,
  input  logic [31:0]            wb_prd_off,
  input  logic [15:0]            wb_prd_cnt,
  input  logic [3:0]             wb_strip,
  output logic [4:0]             out_cfl,
  output logic [5:0]             out_flags,
  output logic [3:0]             out_pmp,
  output logic [15:0]            out_prdtl,
  output logic [31:0]            out_prdbc,
  output logic [31:0]            out_ctba,
  output logic [3:0]             out_strip_index,
  output logic [3:0]             out_strip_total,
  output logic                   out_strip_enable,
  output logic [31:0]            out_prd_off,
  output logic [15:0]            out_prd_cnt,
  output logic [3:0]             out_strip
);
  typedef enum logic [2:0] {IDLE, RD, RDLAST, WB0, WB1, DONE} state_t;
  state_t state, state_n;
  logic [63:0] mem [C_NUM_SLOTS*C_WORDS];
  logic [63:0] rdata, wdata;
  logic [SW+IW-1:0] addr;
  logic [IW-1:0] idx;
  logic [1:0] cap_idx;
  logic [7:0] be;
  logic iss, issue, wb0, wb1, we, miss;
  assign wb0 = ~fill_req & (state == WB0);
  assign wb1 = ~fill_req & (state == WB1);
  assign issue = ~fill_req & (state == RD);
  assign we = (fill_req & fill_we) | wb0 | wb1;
  assign be = wb0 ? 8'hF0 : 8'hFF;
  assign addr = fill_req ? {fill_slot, fill_idx} : {acc.port_slot, wb0 ? IW'(0) : wb1 ? IW'(3) : idx};
  assign wdata = fill_req ? fill_data : wb1 ? {12'h0, wb_strip, wb_prd_cnt, wb_prd_off} : {out_prdbc, 32'h0};
  assign acc.port_ack = state == DONE;
  assign acc.port_miss = miss;
  always_ff @(posedge sys_clk) begin
    for (int b = 0; b < 8; b++)
      if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    rdata <= mem[addr];
  end
  // a fill owns the RAM port outright, so every state simply holds while it lasts
  always_comb begin
    state_n = state;
    if (!fill_req)
      case (state)
        IDLE:    state_n = acc.port_req ? (acc.port_we ? WB0 : RD) : IDLE;
        RD:      state_n = (idx == IW'(3)) ? RDLAST : RD;
        RDLAST:  state_n = DONE;
        WB0:     state_n = WB1;
        WB1:     state_n = DONE;
        DONE:    state_n = acc.port_req ? DONE : IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      idx <= '0;
      iss <= 1'b0;
      cap_idx <= '0;
      miss <= 1'b0;
      valid_map <= '0;
      out_cfl <= '0;
      out_flags <= '0;
      out_pmp <= '0;
      out_prdtl <= '0;
      out_prdbc <= '0;
      out_ctba <= '0;
      out_strip_index <= '0;
      out_strip_total <= '0;
      out_strip_enable <= 1'b0;
      out_prd_off <= '0;
      out_prd_cnt <= '0;
      out_strip <= '0;
    end else begin
      state <= state_n;
      iss <= issue;
      cap_idx <= idx[1:0];
      if (!fill_req && state == IDLE && acc.port_req) begin
        idx <= '0;
        miss <= ~acc.port_we & ~valid_map[acc.port_slot];
      end else if (issue) idx <= idx + IW'(1);
      if (fill_req && fill_we && fill_idx == IW'(C_WORDS-1)) valid_map[fill_slot] <= 1'b1;
      if (inv_req) valid_map[inv_slot] <= 1'b0;
      // rdata only belongs to the port when the previous cycle issued a port read
      if (iss && cap_idx == 2'd0) begin
        out_cfl <= rdata[4:0];
        out_flags <= rdata[10:5];
        out_pmp <= rdata[15:12];
        out_prdtl <= rdata[31:16];
        out_prdbc <= rdata[63:32];
      end else if (prdbc_incr) out_prdbc <= out_prdbc + 32'(C_PRDBC_STEP);
      if (iss && cap_idx == 2'd1) out_ctba <= rdata[31:0];
      if (iss && cap_idx == 2'd2) begin
        out_strip_index <= rdata[3:0];
        out_strip_total <= rdata[11:8];
        out_strip_enable <= rdata[15];
      end
      if (iss && cap_idx == 2'd3) begin
        out_prd_off <= rdata[31:0];
        out_prd_cnt <= rdata[47:32];
        out_strip <= rdata[51:48];
      end
    end
  end
endmodule

// File: tb/tb_cmdhdr_cache.sv
// tb_cmdhdr_cache: directed checks of fill, decode, stalls, writeback, invalidate, PRDBC wrap and reset
module tb_cmdhdr_cache;
  localparam int NS = 32, SW = 5, IW = 2;
  logic sys_clk = 0, sys_rst_n = 0;
  always #5 sys_clk = ~sys_clk;
  logic fill_req = 0, fill_we = 0, inv_req = 0, prdbc_incr = 0;
  logic [SW-1:0] fill_slot = '0, inv_slot = '0;
  logic [IW-1:0] fill_idx = '0;
  logic [63:0] fill_data = '0;
  logic [31:0] wb_prd_off = '0;
  logic [15:0] wb_prd_cnt = '0;
  logic [3:0] wb_strip = '0;
  logic [NS-1:0] valid_map;
  logic [4:0] out_cfl;
  logic [5:0] out_flags;
  logic [3:0] out_pmp, out_strip_index, out_strip_total, out_strip;
  logic [15:0] out_prdtl, out_prd_cnt;
  logic [31:0] out_prdbc, out_ctba, out_prd_off;
  logic out_strip_enable;
  int n_chk = 0, n_fail = 0, lat;
  cmdhdr_cache_if #(.SW(SW)) bus ();
  cmdhdr_cache #(.C_NUM_SLOTS(NS), .C_WORDS(4), .C_PRDBC_STEP(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .fill_req(fill_req), .fill_slot(fill_slot),
    .fill_idx(fill_idx), .fill_we(fill_we), .fill_data(fill_data), .acc(bus),
    .inv_req(inv_req), .inv_slot(inv_slot), .valid_map(valid_map), .prdbc_incr(prdbc_incr),
    .wb_prd_off(wb_prd_off), .wb_prd_cnt(wb_prd_cnt), .wb_strip(wb_strip),
    .out_cfl(out_cfl), .out_flags(out_flags), .out_pmp(out_pmp), .out_prdtl(out_prdtl),
    .out_prdbc(out_prdbc), .out_ctba(out_ctba), .out_strip_index(out_strip_index),
    .out_strip_total(out_strip_total), .out_strip_enable(out_strip_enable),
    .out_prd_off(out_prd_off), .out_prd_cnt(out_prd_cnt), .out_strip(out_strip));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [SW-1:0] s, input logic [IW-1:0] i, input logic [63:0] d);
    @(negedge sys_clk);
    fill_req = 1; fill_we = 1; fill_slot = s; fill_idx = i; fill_data = d;
    @(negedge sys_clk);
    fill_req = 0; fill_we = 0;
  endtask

  // lat counts edges from the sampling edge to the one raising port_ack; fill_req is
  // asserted (reads only, slot 9) on the edges numbered lo..hi
  task automatic access(input logic we, input logic [SW-1:0] s, input int lo, input int hi, output int l);
    @(negedge sys_clk);
    bus.port_we = we; bus.port_slot = s; bus.port_req = 1; l = 0;
    while (l < 40) begin
      @(posedge sys_clk); #1;
      if (bus.port_ack) break;
      l++;
      @(negedge sys_clk);
      fill_req = (l >= lo && l <= hi); fill_we = 0; fill_slot = 5'd9; fill_idx = l[1:0];
    end
    fill_req = 0;
  endtask

  task automatic release_acc();
    @(negedge sys_clk);
    bus.port_req = 0;
    @(posedge sys_clk); #1;
    chk("ack_drop", bus.port_ack, 1'b0);
  endtask

  task automatic pulse_incr();
    @(negedge sys_clk); prdbc_incr = 1;
    @(negedge sys_clk); prdbc_incr = 0;
  endtask

  initial begin
    bus.port_req = 0; bus.port_we = 0; bus.port_slot = '0;
    #12;
    chk("rst_ack", bus.port_ack, 1'b0);
    chk("rst_valid", valid_map, '0);
    chk("rst_prdbc", out_prdbc, 32'h0);
    @(negedge sys_clk) sys_rst_n = 1;
    fill(5, 0, 64'h0000_1000_0003_0045);
    fill(5, 1, 64'h0000_0000_8000_0400);
    fill(5, 2, 64'h0000_0000_0000_8302);
    fill(5, 3, 64'h0005_0004_0000_0100);
    for (int i = 0; i < 4; i++) fill(9, IW'(i), 64'hAAAA_AAAA_AAAA_AAAA);
    chk("valid_after_fill", valid_map, 32'h0000_0220);
    access(0, 5, 1, 0, lat);
    chk("rd_lat", lat, 5);
    chk("rd_miss", bus.port_miss, 1'b0);
    chk("rd_cfl", out_cfl, 5);
    chk("rd_flags", out_flags, 6'b000010);
    chk("rd_pmp", out_pmp, 0);
    chk("rd_prdtl", out_prdtl, 3);
    chk("rd_prdbc", out_prdbc, 32'h1000);
    chk("rd_ctba", out_ctba, 32'h8000_0400);
    chk("rd_strip_fields", {out_strip_enable, out_strip_total, out_strip_index}, {1'b1, 4'd3, 4'd2});
    chk("rd_prd", {out_strip, out_prd_cnt, out_prd_off}, {4'd5, 16'd4, 32'h100});
    release_acc();
    access(0, 7, 1, 0, lat);
    chk("miss_lat", lat, 5);
    chk("miss_flag", bus.port_miss, 1'b1);
    release_acc();
    access(0, 5, 2, 4, lat);
    chk("stall_lat", lat, 8);
    chk("stall_miss", bus.port_miss, 1'b0);
    chk("stall_cfl", out_cfl, 5);
    chk("stall_prdbc", out_prdbc, 32'h1000);
    chk("stall_ctba", out_ctba, 32'h8000_0400);
    chk("stall_strip_fields", {out_strip_enable, out_strip_total, out_strip_index}, {1'b1, 4'd3, 4'd2});
    chk("stall_prd", {out_strip, out_prd_cnt, out_prd_off}, {4'd5, 16'd4, 32'h100});
    release_acc();
    repeat (3) pulse_incr();
    chk("incr3", out_prdbc, 32'h100C);
    wb_prd_off = 32'h200; wb_prd_cnt = 16'd2; wb_strip = 4'd1;
    access(1, 5, 1, 0, lat);
    chk("wb_lat", lat, 2);
    chk("wb_miss", bus.port_miss, 1'b0);
    release_acc();
    access(0, 5, 1, 0, lat);
    chk("rerd_prdbc", out_prdbc, 32'h100C);
    chk("rerd_prd_off", out_prd_off, 32'h200);
    chk("rerd_prd_cnt", out_prd_cnt, 16'd2);
    chk("rerd_strip", out_strip, 4'd1);
    chk("rerd_cfl", out_cfl, 5);
    chk("rerd_prdtl", out_prdtl, 3);
    release_acc();
    @(negedge sys_clk);
    fill_req = 1; fill_we = 1; fill_slot = 5; fill_idx = 3; fill_data = 64'h0001_0002_0000_0200;
    inv_req = 1; inv_slot = 5;
    @(negedge sys_clk);
    fill_req = 0; fill_we = 0; inv_req = 0;
    chk("inv_wins", valid_map, 32'h0000_0200);
    fill(5, 0, 64'hFFFF_FFFC_0003_0045);
    access(0, 5, 1, 0, lat);
    chk("inv_rd_miss", bus.port_miss, 1'b1);
    chk("inv_rd_prdbc", out_prdbc, 32'hFFFF_FFFC);
    chk("inv_rd_cfl", out_cfl, 5);
    release_acc();
    pulse_incr();
    chk("prdbc_wrap", out_prdbc, 32'h0);
    prdbc_incr = 1;
    access(0, 5, 1, 0, lat);
    prdbc_incr = 0;
    chk("incr_vs_capture", out_prdbc, 32'h8);
    release_acc();
    @(negedge sys_clk);
    bus.port_we = 0; bus.port_slot = 5; bus.port_req = 1;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #2 sys_rst_n = 0;
    #1;
    chk("mid_rst_ack", bus.port_ack, 1'b0);
    chk("mid_rst_miss", bus.port_miss, 1'b0);
    chk("mid_rst_valid", valid_map, '0);
    chk("mid_rst_fields", {out_cfl, out_prdbc, out_ctba, out_prd_off}, '0);
    bus.port_req = 0;
    @(negedge sys_clk) sys_rst_n = 1;
    access(0, 5, 1, 0, lat);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_miss", bus.port_miss, 1'b1);
    chk("post_rst_cfl", out_cfl, 5);
    chk("post_rst_ctba", out_ctba, 32'h8000_0400);
    release_acc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
